// File: rtl/ld_project.sv
// Settings controller for two fridges, two ACs and two washers.
// Optional: define ACTIMER_COUNTDOWN_EN to make each AC timer count down to 0.
module ld_project (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       s4,
    input  logic       s5,
    input  logic [4:0] inp,
    input  logic [4:0] wash,
    input  logic [4:0] rinse,
    input  logic [4:0] spin,
    input  logic [4:0] cloth,
    output logic [4:0] fgt1,
    output logic [4:0] frt1,
    output logic [4:0] fgc1,
    output logic [4:0] frc1,
    output logic [4:0] fgt2,
    output logic [4:0] frt2,
    output logic [4:0] fgc2,
    output logic [4:0] frc2,
    output logic       ice1,
    output logic       ice2,
    output logic [4:0] actemp1,
    output logic [4:0] accap1,
    output logic [4:0] acfan1,
    output logic [4:0] actimer1,
    output logic [4:0] actemp2,
    output logic [4:0] accap2,
    output logic [4:0] acfan2,
    output logic [4:0] actimer2,
    output logic [4:0] wash_out_1,
    output logic [4:0] rinse_out_1,
    output logic [4:0] spin_out_1,
    output logic [4:0] cloth_out_1,
    output logic [4:0] wash_out_2,
    output logic [4:0] rinse_out_2,
    output logic [4:0] spin_out_2,
    output logic [4:0] cloth_out_2
);

    localparam logic [1:0] CLS_FRIDGE = 2'b00;
    localparam logic [1:0] CLS_AC     = 2'b01;
    localparam logic [1:0] CLS_WASHER = 2'b10;

    logic [1:0] dev_class;
    logic [1:0] field;

    assign dev_class = {s0, s1};
    assign field     = {s3, s4};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit
            localparam logic UNIT_ID = 1'(gi);

            logic       unit_sel;
            logic [4:0] fgt_reg, frt_reg, fgc_reg, frc_reg;
            logic       ice_reg;
            logic [4:0] actemp_reg, accap_reg, acfan_reg, actimer_reg;
            logic [4:0] wash_reg, rinse_reg, spin_reg, cloth_reg;

            assign unit_sel = (s2 == UNIT_ID);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    fgt_reg     <= '0;
                    frt_reg     <= '0;
                    fgc_reg     <= '0;
                    frc_reg     <= '0;
                    ice_reg     <= 1'b0;
                    actemp_reg  <= '0;
                    accap_reg   <= '0;
                    acfan_reg   <= '0;
                    actimer_reg <= '0;
                    wash_reg    <= '0;
                    rinse_reg   <= '0;
                    spin_reg    <= '0;
                    cloth_reg   <= '0;
                end else begin
`ifdef ACTIMER_COUNTDOWN_EN
                    // A timer write further down overrides this decrement.
                    if (actimer_reg != 5'd0) begin
                        actimer_reg <= actimer_reg - 5'd1;
                    end
`endif
                    if (unit_sel) begin
                        case (dev_class)
                            CLS_FRIDGE: begin
                                // s5 is only consulted for the temperature/capacity fields.
                                case (field)
                                    2'b00: begin
                                        if (s5) frt_reg <= inp;
                                        else    fgt_reg <= inp;
                                    end
                                    2'b01: begin
                                        if (s5) frc_reg <= inp;
                                        else    fgc_reg <= inp;
                                    end
                                    2'b10:   ice_reg <= inp[0];
                                    default: ;
                                endcase
                            end
                            CLS_AC: begin
                                case (field)
                                    2'b00:   actemp_reg  <= inp;
                                    2'b01:   accap_reg   <= inp;
                                    2'b10:   acfan_reg   <= inp;
                                    default: actimer_reg <= inp;
                                endcase
                            end
                            CLS_WASHER: begin
                                if (s3) begin
                                    wash_reg  <= '0;
                                    rinse_reg <= '0;
                                    spin_reg  <= '0;
                                    cloth_reg <= '0;
                                end else begin
                                    wash_reg  <= wash;
                                    rinse_reg <= rinse;
                                    spin_reg  <= spin;
                                    cloth_reg <= cloth;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    endgenerate

    assign fgt1        = g_unit[0].fgt_reg;
    assign frt1        = g_unit[0].frt_reg;
    assign fgc1        = g_unit[0].fgc_reg;
    assign frc1        = g_unit[0].frc_reg;
    assign fgt2        = g_unit[1].fgt_reg;
    assign frt2        = g_unit[1].frt_reg;
    assign fgc2        = g_unit[1].fgc_reg;
    assign frc2        = g_unit[1].frc_reg;
    assign ice1        = g_unit[0].ice_reg;
    assign ice2        = g_unit[1].ice_reg;
    assign actemp1     = g_unit[0].actemp_reg;
    assign accap1      = g_unit[0].accap_reg;
    assign acfan1      = g_unit[0].acfan_reg;
    assign actimer1    = g_unit[0].actimer_reg;
    assign actemp2     = g_unit[1].actemp_reg;
    assign accap2      = g_unit[1].accap_reg;
    assign acfan2      = g_unit[1].acfan_reg;
    assign actimer2    = g_unit[1].actimer_reg;
    assign wash_out_1  = g_unit[0].wash_reg;
    assign rinse_out_1 = g_unit[0].rinse_reg;
    assign spin_out_1  = g_unit[0].spin_reg;
    assign cloth_out_1 = g_unit[0].cloth_reg;
    assign wash_out_2  = g_unit[1].wash_reg;
    assign rinse_out_2 = g_unit[1].rinse_reg;
    assign spin_out_2  = g_unit[1].spin_reg;
    assign cloth_out_2 = g_unit[1].cloth_reg;

endmodule

// File: tb/tb_ld_project.sv
// Randomized bench for ld_project against a table-based settings model.
// Honours ACTIMER_COUNTDOWN_EN the same way as the design.
module tb_ld_project;

    logic       clk = 1'b0;
    logic       rst_n, s0, s1, s2, s3, s4, s5;
    logic [4:0] inp, wash, rinse, spin, cloth;
    logic [4:0] fgt1, frt1, fgc1, frc1, fgt2, frt2, fgc2, frc2;
    logic       ice1, ice2;
    logic [4:0] actemp1, accap1, acfan1, actimer1, actemp2, accap2, acfan2, actimer2;
    logic [4:0] wash_out_1, rinse_out_1, spin_out_1, cloth_out_1;
    logic [4:0] wash_out_2, rinse_out_2, spin_out_2, cloth_out_2;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: fridge index 0 fgt,1 frt,2 fgc,3 frc; AC index = field; washer 0 wash..3 cloth.
    logic [4:0] m_fr [2][4];
    logic       m_ice[2];
    logic [4:0] m_ac [2][4];
    logic [4:0] m_wa [2][4];

    logic [4:0] d_fr [2][4];
    logic       d_ice[2];
    logic [4:0] d_ac [2][4];
    logic [4:0] d_wa [2][4];

    always #5 clk = ~clk;

    ld_project dut (
        .clk(clk), .rst_n(rst_n),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .inp(inp), .wash(wash), .rinse(rinse), .spin(spin), .cloth(cloth),
        .fgt1(fgt1), .frt1(frt1), .fgc1(fgc1), .frc1(frc1),
        .fgt2(fgt2), .frt2(frt2), .fgc2(fgc2), .frc2(frc2),
        .ice1(ice1), .ice2(ice2),
        .actemp1(actemp1), .accap1(accap1), .acfan1(acfan1), .actimer1(actimer1),
        .actemp2(actemp2), .accap2(accap2), .acfan2(acfan2), .actimer2(actimer2),
        .wash_out_1(wash_out_1), .rinse_out_1(rinse_out_1),
        .spin_out_1(spin_out_1), .cloth_out_1(cloth_out_1),
        .wash_out_2(wash_out_2), .rinse_out_2(rinse_out_2),
        .spin_out_2(spin_out_2), .cloth_out_2(cloth_out_2)
    );

    always_comb begin
        d_fr[0][0] = fgt1; d_fr[0][1] = frt1; d_fr[0][2] = fgc1; d_fr[0][3] = frc1;
        d_fr[1][0] = fgt2; d_fr[1][1] = frt2; d_fr[1][2] = fgc2; d_fr[1][3] = frc2;
        d_ice[0] = ice1;   d_ice[1] = ice2;
        d_ac[0][0] = actemp1; d_ac[0][1] = accap1; d_ac[0][2] = acfan1; d_ac[0][3] = actimer1;
        d_ac[1][0] = actemp2; d_ac[1][1] = accap2; d_ac[1][2] = acfan2; d_ac[1][3] = actimer2;
        d_wa[0][0] = wash_out_1; d_wa[0][1] = rinse_out_1; d_wa[0][2] = spin_out_1; d_wa[0][3] = cloth_out_1;
        d_wa[1][0] = wash_out_2; d_wa[1][1] = rinse_out_2; d_wa[1][2] = spin_out_2; d_wa[1][3] = cloth_out_2;
    end

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("fridge[%0d][%0d]", u + 1, i), d_fr[u][i], m_fr[u][i]);
                check($sformatf("ac[%0d][%0d]", u + 1, i), d_ac[u][i], m_ac[u][i]);
                check($sformatf("washer[%0d][%0d]", u + 1, i), d_wa[u][i], m_wa[u][i]);
            end
            check($sformatf("ice%0d", u + 1), {4'b0, d_ice[u]}, {4'b0, m_ice[u]});
        end
    endtask

    // Settings model: applied once per rising edge using the sampled command.
    task automatic model_update();
        int u;
        logic [1:0] cls, fld;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ice[k] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_fr[k][i] = 0; m_ac[k][i] = 0; m_wa[k][i] = 0;
                end
            end
            return;
        end
`ifdef ACTIMER_COUNTDOWN_EN
        for (int k = 0; k < 2; k++)
            if (m_ac[k][3] != 0) m_ac[k][3] = m_ac[k][3] - 1;
`endif
        u   = s2 ? 1 : 0;
        cls = {s0, s1};
        fld = {s3, s4};
        case (cls)
            2'b00: begin
                if (fld == 2'b00)      m_fr[u][s5 ? 1 : 0] = inp;
                else if (fld == 2'b01) m_fr[u][s5 ? 3 : 2] = inp;
                else if (fld == 2'b10) m_ice[u] = inp[0];
            end
            2'b01: m_ac[u][fld] = inp;
            2'b10: begin
                if (s3) for (int i = 0; i < 4; i++) m_wa[u][i] = 0;
                else begin
                    m_wa[u][0] = wash; m_wa[u][1] = rinse;
                    m_wa[u][2] = spin; m_wa[u][3] = cloth;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one command, clock it, update the model and compare everything.
    task automatic cmd(input logic r, input logic [1:0] cls, input logic u,
                       input logic [1:0] fld, input logic sel5, input logic [4:0] v,
                       input logic [19:0] wv);
        rst_n = r; {s0, s1} = cls; s2 = u; {s3, s4} = fld; s5 = sel5; inp = v;
        {wash, rinse, spin, cloth} = wv;
        @(posedge clk);
        model_update();
        #1;
        $display("t=%0t rst_n=%0b cls=%0d unit=%0d field=%0d s5=%0b inp=%0d wv=%h",
                 $time, r, cls, u, fld, sel5, v, wv);
        check_all();
    endtask

    task automatic cmd_rand(input logic r);
        cmd(r, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom), 20'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; s0 = 0; s1 = 0; s2 = 0; s3 = 0; s4 = 0; s5 = 0;
        inp = 0; wash = 0; rinse = 0; spin = 0; cloth = 0;
        @(negedge clk);

        // Reset with random commands, then idle.
        cmd_rand(1'b0);
        cmd_rand(1'b0);
        check("rst_fgt1", fgt1, 5'd0);
        check("rst_wash2", wash_out_2, 5'd0);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd17, 20'hFFFFF);
        check("idle_actemp1", actemp1, 5'd0);

        // Fridge
        cmd(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'b10101, 20'h0);
        check("fgt1_21", fgt1, 5'd21);
        cmd(1'b1, 2'b00, 1'b1, 2'b01, 1'b1, 5'b11111, 20'h0);
        check("frc2_31", frc2, 5'd31);

        // Icemaker; s5 is a don't-care here
        cmd(1'b1, 2'b00, 1'b0, 2'b10, 1'bx, 5'b00001, 20'h0);
        cmd(1'b1, 2'b00, 1'b1, 2'b10, 1'bx, 5'b00001, 20'h0);
        check("ice1_set", {4'b0, ice1}, 5'd1);
        check("ice2_set", {4'b0, ice2}, 5'd1);
        check("fgt1_kept", fgt1, 5'd21);
        cmd(1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 5'b00000, 20'h0);
        check("ice2_clr", {4'b0, ice2}, 5'd0);

        // AC
        cmd(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 5'b01010, 20'h0);
        check("acfan2_10", acfan2, 5'd10);
        cmd(1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 5'b00100, 20'h0);
        check("accap1_4", accap1, 5'd4);
        check("acfan2_kept", acfan2, 5'd10);

        // Washer load then cancel
        cmd(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 5'd0, 20'hFFFFF);
        check("wash1_31", wash_out_1, 5'd31);
        check("cloth1_31", cloth_out_1, 5'd31);
        check("wash2_kept", wash_out_2, 5'd0);
        cmd(1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 5'd0, 20'hFFFFF);
        check("wash1_cancel", wash_out_1, 5'd0);
        check("spin1_cancel", spin_out_1, 5'd0);

`ifdef ACTIMER_COUNTDOWN_EN
        cmd(1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 5'd3, 20'h0);
        check("timer_load3", actimer1, 5'd3);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_2", actimer1, 5'd2);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_1", actimer1, 5'd1);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_0", actimer1, 5'd0);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_stop0", actimer1, 5'd0);
        cmd(1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 5'd4, 20'h0);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_3b", actimer1, 5'd3);
        cmd(1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 5'd5, 20'h0);
        check("timer_rewrite5", actimer1, 5'd5);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_4", actimer1, 5'd4);
`else
        cmd(1'b1, 2'b01, 1'b0, 2'b11, 1'b0, 5'd3, 20'h0);
        cmd(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 20'h0);
        check("timer_hold", actimer1, 5'd3);
`endif

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            cmd_rand(($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ld_project.md
Name: ld_project

Overview:
- Smart-home appliance settings controller for two fridges, two air conditioners and two washing machines.
- A selector bus picks a device class, unit and field each cycle; the selected register loads the shared 5-bit value on the clock edge.
- All settings are held in registers and driven continuously to the display/actuator logic.

Parameters:
- None. All data fields are fixed at 5 bits.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- s0, s1  input  1 each  device class select: {s0,s1}=00 fridge, 01 AC, 10 washer, 11 idle (no write).
- s2  input  1  unit select: 0 = unit 1, 1 = unit 2.
- s3, s4  input  1 each  field select within the class.
- s5  input  1  fridge compartment: 0 = fridge, 1 = freezer. Ignored for all other commands.
- inp  input  5  value for fridge and AC writes.
- wash, rinse, spin, cloth  input  5 each  washer program values.
- fgt1, frt1, fgc1, frc1, fgt2, frt2, fgc2, frc2  output  5 each  fridge temperature, freezer temperature, fridge capacity and freezer capacity, per unit.
- ice1, ice2  output  1 each  icemaker enable per unit.
- actemp1, accap1, acfan1, actimer1, actemp2, accap2, acfan2, actimer2  output  5 each  AC temperature, capacity, fan speed and timer, per unit.
- wash_out_1, rinse_out_1, spin_out_1, cloth_out_1, wash_out_2, rinse_out_2, spin_out_2, cloth_out_2  output  5 each  washer program registers.

Behaviour:
- Reset: rst_n sampled low at a rising clk edge clears every output register to 0. Reset has priority over any command.
- General write rules:
  - At most one register group is written per rising edge.
  - Unselected registers hold their value.
  - Commands are level-based: a command held for N cycles rewrites the register every cycle.
  - A written value is visible on the output directly after the capturing edge (1-cycle latency). Outputs are pure register outputs.
- Fridge ({s0,s1}=00), unit chosen by s2:
  - {s3,s4}=00: temperature write. s5=0 loads fgtN <= inp; s5=1 loads frtN <= inp.
  - {s3,s4}=01: capacity write. s5=0 loads fgcN <= inp; s5=1 loads frcN <= inp.
  - {s3,s4}=10: iceN <= inp[0]. s5 is don't-care; an X on s5 must not corrupt any register.
  - {s3,s4}=11: no write.
- AC ({s0,s1}=01), unit chosen by s2:
  - {s3,s4}=00 loads actempN <= inp.
  - 01 loads accapN <= inp.
  - 10 loads acfanN <= inp.
  - 11 loads actimerN <= inp.
- Washer ({s0,s1}=10), unit chosen by s2:
  - s3=0: load wash_out_N, rinse_out_N, spin_out_N and cloth_out_N from wash, rinse, spin and cloth in the same edge.
  - s3=1: cancel; clear all four registers of that unit to 0.
  - s4 and s5 are ignored.
- Idle ({s0,s1}=11): no register changes.
- Values are stored unmodified over the full 0..31 range, with no clamping or wrap arithmetic. Only inp[0] is used for ice.

Optional Feature:
- Macro ACTIMER_COUNTDOWN_EN.
- Defined: each actimerN that is nonzero and not being written this edge decrements by 1 per rising edge and stops at 0. A write in the same cycle takes priority over the decrement. Reset still clears the timer to 0.
- Undefined: actimerN is a plain hold register, written only by the AC timer command.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random commands applied -> every output is 0. Release rst_n -> outputs stay 0 under the idle command 11.
- Fridge: {s0,s1}=00, s2=0, {s3,s4}=00, s5=0, inp=10101 -> fgt1=21, all other registers unchanged. Then s2=1, {s3,s4}=01, s5=1, inp=11111 -> frc2=31.
- Icemaker: {s0,s1}=00, {s3,s4}=10, s5=X, inp=00001 for s2=0 then s2=1 -> ice1=1, ice2=1, no other change. Then inp=0 -> ice cleared.
- AC: {s0,s1}=01, s2=1, {s3,s4}=10, inp=01010 -> acfan2=10. Then s2=0, {s3,s4}=01, inp=00100 -> accap1=4, acfan2 still 10.
- Washer: {s0,s1}=10, s2=0, s3=0, all four inputs=11111 -> unit-1 washer outputs all 31, unit 2 unchanged. Next cycle s3=1 -> unit-1 washer outputs all 0.
- Countdown (ACTIMER_COUNTDOWN_EN defined): write actimer1=3, then idle -> actimer1 reads 2, 1, 0, 0 on successive edges. A rewrite to 5 mid-count takes effect immediately.
